lsu_ahb_master: RTL and testbench
=================================

// Module: lsu_ahb_master
// PURPOSE
//  CPU load/store-side AHB master driving the data-memory slave. Takes byte/half/word
//  load/store requests, issues word-only AHB transfers, waits on hready_i, extracts and
//  sign/zero-extends load data, and performs read-modify-write for sub-word stores.
//  Sub-word stores need RMW because the data SRAM has one write enable and no byte mask.
// PARAMETERS
//  DATA_WIDTH      32   bus/data width (only 32 supported)
//  TIMEOUT_CYCLES  64   max cycles waiting for hready_i before abort with error (>=2)
// PORTS
//  hclk_i     in   1   clock, all state on rising edge
//  hreset_i   in   1   reset, asynchronous, active-high
//  req_i      in   1   CPU request; sampled only in IDLE
//  we_i       in   1   1=store, 0=load
//  size_i     in   2   00 byte, 01 half, 10 word, 11 illegal
//  unsigned_i in   1   load zero-extend (1) / sign-extend (0)
//  addr_i     in   32  byte address
//  wdata_i    in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//  rdata_o    out  32  extended load data, valid while done_o=1
//  done_o     out  1   one-cycle completion pulse
//  err_o      out  1   with done_o: misaligned/illegal size/hresp_i/timeout
//  busy_o     out  1   high in every state except IDLE
//  haddr_o    out  32  {addr[31:2],2'b00}
//  htrans_o   out  2   00 IDLE, 10 NONSEQ
//  hwrite_o   out  1   AHB write
//  hsize_o    out  3   constant 3'b010
//  hwdata_o   out  32  write data, held for whole transfer
//  hrdata_i   in   32  AHB read data
//  hready_i   in   1   transfer complete
//  hresp_i    in   1   error response, qualified by hready_i
// BEHAVIOUR
//  Reset (async): state IDLE; htrans_o=00, hwrite_o=0, haddr_o=0, hwdata_o=0, rdata_o=0,
//   done_o=0, err_o=0, busy_o=0, timeout counter=0. Reset mid-transfer abandons it; no done_o.
//  Non-pipelined bus: haddr_o/hwrite_o/hwdata_o/htrans_o are registered, stable from
//   transfer start until the cycle hready_i=1 is sampled; htrans_o=IDLE >=1 cycle between transfers.
//  IDLE: req_i=1 captures we/size/unsigned/addr/wdata. Misaligned (half addr[0]=1, word
//   addr[1:0]!=0) or size=11 -> RESP with err, no bus activity. Load -> RD. Word store -> WR.
//   Byte/half store -> RMW_RD.
//  RD: NONSEQ read; on hready_i: lane-select by addr[1:0], extend -> rdata_o; -> RESP.
//  WR: NONSEQ write, hwdata_o=wdata; on hready_i -> RESP.
//  RMW_RD: NONSEQ read; on hready_i merge store bytes into read word -> GAP.
//  GAP: htrans_o=IDLE one cycle -> RMW_WR.  RMW_WR: NONSEQ write of merged word -> RESP.
//  hready_i=1 with hresp_i=1 in any bus state -> RESP with err; RMW aborts, no write issued.
//  Timeout counter clears on entry to each bus state, increments each cycle hready_i=0;
//   reaching TIMEOUT_CYCLES -> htrans_o=IDLE, RESP with err.
//  RESP: done_o=1 one cycle (err_o valid), htrans_o=IDLE -> IDLE. Next req accepted the
//   cycle after RESP. req_i ignored while busy_o=1. rdata_o=0 for stores and errors.
//  Little-endian lanes: byte lane addr[1:0], half lane addr[1]. Extension by size/unsigned_i.
//  Latency: load/word store = 1 + wait cycles + 1 (RESP); RMW = 2 transfers + GAP + RESP.
// STRUCTURE
//  Package svarog_lsu_pkg: size_e (SZ_BYTE/SZ_HALF/SZ_WORD), HTRANS_IDLE/HTRANS_NONSEQ,
//   HSIZE_WORD, lsu_state_e (IDLE,RD,WR,RMW_RD,GAP,RMW_WR,RESP).
//  Sub-module lsu_lane_align (combinational): load extract+extend and store merge by
//   addr[1:0]/size. Top holds FSM, capture regs, timeout counter.
// TESTING
//  Load byte 0x103 signed, slave word 0x80FF_1234, 3 wait cycles -> haddr_o=0x100,
//   rdata_o=0xFFFF_FF80, done_o 1 cycle, err_o=0.
//  Load half 0x102 unsigned, word 0x80FF_1234 -> rdata_o=0x0000_80FF.
//  Store byte 0xAB @0x101, memory 0x1122_3344 -> read, one IDLE cycle, write 0x1122_AB44.
//  Word store addr 0x102 -> done_o+err_o next cycle, htrans_o stays IDLE throughout.
//  hready_i held 0 -> after TIMEOUT_CYCLES err_o pulse, busy_o=0 the cycle after RESP.
//  hresp_i=1 on RMW read -> err_o, no write transfer; hreset_i mid-RD -> outputs at reset values.

Source files
------------

// File: rtl/svarog_lsu_pkg.sv
// Shared types and constants for the load/store-unit AHB master.
// Only word-sized AHB transfers are issued; sub-word access is handled in the lane logic.
package svarog_lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      GAP    = 3'd4,
      RMW_WR = 3'd5,
      RESP   = 3'd6
   } lsu_state_e;

   // Misaligned half/word or the reserved size code; such requests never reach the bus.
   function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a bus word, and
// merges sub-word store data into a read word for the read-modify-write path.
module lsu_lane_align
   import svarog_lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      case (addr_lo)
         2'd0:    lane_byte = rword[7:0];
         2'd1:    lane_byte = rword[15:8];
         2'd2:    lane_byte = rword[23:16];
         default: lane_byte = rword[31:24];
      endcase
      lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   always_comb begin
      load_data = rword;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
            merged    = rword;
            case (addr_lo)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
            merged    = rword;
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         default: begin
            load_data = rword;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ahb_master.sv
// Non-pipelined AHB master for CPU loads/stores; sub-word stores use read-modify-write
// because the data SRAM has a single write enable and no byte mask.
//
// state  | meaning
// IDLE   | waiting for req_i
// RD     | NONSEQ read for a load
// WR     | NONSEQ write for a word store
// RMW_RD | NONSEQ read of the word a sub-word store lands in
// GAP    | one bus-idle cycle between the RMW read and write
// RMW_WR | NONSEQ write of the merged word
// RESP   | done_o/err_o pulse back to the CPU
module lsu_ahb_master
   import svarog_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic                  hclk_i,
   input  logic                  hreset_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [31:0]           addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic [31:0]           haddr_o,
   output logic [1:0]            htrans_o,
   output logic                  hwrite_o,
   output logic [2:0]            hsize_o,
   output logic [DATA_WIDTH-1:0] hwdata_o,
   input  logic [DATA_WIDTH-1:0] hrdata_i,
   input  logic                  hready_i,
   input  logic                  hresp_i
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e            state, state_nxt;
   logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
   logic [1:0]            addr_lo_q, addr_lo_nxt;
   logic [1:0]            size_q, size_nxt;
   logic                  unsigned_q, unsigned_nxt;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
   logic [1:0]            htrans_nxt;
   logic                  hwrite_nxt;
   logic [31:0]           haddr_nxt;
   logic [DATA_WIDTH-1:0] hwdata_nxt, rdata_nxt;
   logic                  done_nxt, err_nxt;
   logic [DATA_WIDTH-1:0] load_word, merged_word;

   lsu_lane_align u_lane_align (
      .addr_lo     (addr_lo_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .rword       (hrdata_i),
      .wdata       (wdata_q),
      .load_data   (load_word),
      .merged      (merged_word)
   );

   assign hsize_o = HSIZE_WORD;
   assign busy_o  = (state != IDLE);

   always_ff @(posedge hclk_i or posedge hreset_i) begin
      if (hreset_i) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         addr_lo_q  <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         htrans_o   <= HTRANS_IDLE;
         hwrite_o   <= 1'b0;
         haddr_o    <= '0;
         hwdata_o   <= '0;
         rdata_o    <= '0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         state      <= state_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         addr_lo_q  <= addr_lo_nxt;
         size_q     <= size_nxt;
         unsigned_q <= unsigned_nxt;
         wdata_q    <= wdata_nxt;
         htrans_o   <= htrans_nxt;
         hwrite_o   <= hwrite_nxt;
         haddr_o    <= haddr_nxt;
         hwdata_o   <= hwdata_nxt;
         rdata_o    <= rdata_nxt;
         done_o     <= done_nxt;
         err_o      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tmo_cnt_nxt  = tmo_cnt;
      addr_lo_nxt  = addr_lo_q;
      size_nxt     = size_q;
      unsigned_nxt = unsigned_q;
      wdata_nxt    = wdata_q;
      htrans_nxt   = htrans_o;
      hwrite_nxt   = hwrite_o;
      haddr_nxt    = haddr_o;
      hwdata_nxt   = hwdata_o;
      rdata_nxt    = rdata_o;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (req_i) begin
               addr_lo_nxt  = addr_i[1:0];
               size_nxt     = size_i;
               unsigned_nxt = unsigned_i;
               wdata_nxt    = wdata_i;
               tmo_cnt_nxt  = '0;
               if (req_illegal(size_i, addr_i[1:0])) begin
                  state_nxt = RESP;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
                  rdata_nxt = '0;
               end else begin
                  haddr_nxt  = {addr_i[31:2], 2'b00};
                  htrans_nxt = HTRANS_NONSEQ;
                  if (!we_i) begin
                     hwrite_nxt = 1'b0;
                     hwdata_nxt = '0;
                     state_nxt  = RD;
                  end else if (size_i == SZ_WORD) begin
                     hwrite_nxt = 1'b1;
                     hwdata_nxt = wdata_i;
                     state_nxt  = WR;
                  end else begin
                     hwrite_nxt = 1'b0;
                     hwdata_nxt = '0;
                     state_nxt  = RMW_RD;
                  end
               end
            end
         end
         RD, WR, RMW_RD, RMW_WR: begin
            if (hready_i) begin
               htrans_nxt  = HTRANS_IDLE;
               tmo_cnt_nxt = '0;
               if (hresp_i) begin
                  state_nxt = RESP;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
                  rdata_nxt = '0;
               end else if (state == RMW_RD) begin
                  hwdata_nxt = merged_word;
                  state_nxt  = GAP;
               end else begin
                  state_nxt = RESP;
                  done_nxt  = 1'b1;
                  rdata_nxt = (state == RD) ? load_word : '0;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               // Slave never answered: drop the transfer and report an error.
               htrans_nxt  = HTRANS_IDLE;
               tmo_cnt_nxt = tmo_cnt + 1'b1;
               state_nxt   = RESP;
               done_nxt    = 1'b1;
               err_nxt     = 1'b1;
               rdata_nxt   = '0;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         GAP: begin
            htrans_nxt  = HTRANS_NONSEQ;
            hwrite_nxt  = 1'b1;
            tmo_cnt_nxt = '0;
            state_nxt   = RMW_WR;
         end
         RESP: begin
            hwrite_nxt = 1'b0;
            state_nxt  = IDLE;
         end
         default: begin
            htrans_nxt = HTRANS_IDLE;
            state_nxt  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Directed bench for lsu_ahb_master: a simple wait-state slave, expected bus transfers and
// CPU responses queued by the stimulus, and a negedge monitor that pops and compares them.
module tb_lsu_ahb_master;
   import svarog_lsu_pkg::*;

   localparam int TMO = 64;

   logic        hclk_i = 1'b0;
   logic        hreset_i;
   logic        req_i, we_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        done_o, err_o, busy_o;
   logic [31:0] haddr_o;
   logic [1:0]  htrans_o;
   logic        hwrite_o;
   logic [2:0]  hsize_o;
   logic [31:0] hwdata_o;
   logic [31:0] hrdata_i;
   logic        hready_i, hresp_i;

   lsu_ahb_master #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .hclk_i(hclk_i), .hreset_i(hreset_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .haddr_o(haddr_o),
      .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hwdata_o(hwdata_o),
      .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
   );

   always #5 hclk_i = ~hclk_i;

   typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} bus_t;
   typedef struct packed {logic [31:0] rdata; logic err;} resp_t;

   bus_t  exp_bus[$];
   resp_t exp_resp[$];
   int    checks = 0;
   int    errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endfunction

   // Slave: cfg_wait wait states per transfer, then hready with cfg_resp.
   int          cfg_wait  = 0;
   logic        cfg_resp  = 1'b0;
   logic [31:0] cfg_rdata = '0;
   int          wait_cnt  = 0;

   initial begin
      hready_i = 1'b1;
      hresp_i  = 1'b0;
      hrdata_i = '0;
      forever begin
         @(posedge hclk_i);
         #1;
         if (htrans_o == HTRANS_NONSEQ) begin
            if (wait_cnt < cfg_wait) begin
               hready_i = 1'b0;
               hresp_i  = 1'b0;
               wait_cnt++;
            end else begin
               hready_i = 1'b1;
               hresp_i  = cfg_resp;
               wait_cnt = 0;
            end
         end else begin
            hready_i = 1'b1;
            hresp_i  = 1'b0;
            wait_cnt = 0;
         end
         hrdata_i = cfg_rdata;
      end
   end

   // Monitor
   logic        prev_valid = 1'b0;
   logic        prev_nonseq, prev_ready, prev_done, prev_write;
   logic [31:0] prev_addr, prev_wdata;

   initial begin
      bus_t  b;
      resp_t r;
      forever begin
         @(negedge hclk_i);
         if (hreset_i) begin
            prev_valid = 1'b0;
         end else begin
            if (done_o) begin
               if (exp_resp.size() == 0) fail_now("unexpected_done", "done_o=1 with no request outstanding");
               else begin
                  r = exp_resp.pop_front();
                  check("rdata", rdata_o, r.rdata);
                  check("err", 32'(err_o), 32'(r.err));
               end
            end
            if (prev_valid && prev_done) check("done_one_cycle", 32'(done_o), 32'd0);
            if (prev_valid && prev_nonseq && prev_ready) check("idle_between", 32'(htrans_o), 32'(HTRANS_IDLE));
            if (htrans_o == HTRANS_NONSEQ) begin
               check("hsize", 32'(hsize_o), 32'(HSIZE_WORD));
               if (prev_valid && prev_nonseq && !prev_ready) begin
                  check("haddr_stable", haddr_o, prev_addr);
                  check("hwrite_stable", 32'(hwrite_o), 32'(prev_write));
                  check("hwdata_stable", hwdata_o, prev_wdata);
               end
               if (hready_i) begin
                  if (exp_bus.size() == 0) fail_now("unexpected_transfer", "NONSEQ completed with none expected");
                  else begin
                     b = exp_bus.pop_front();
                     check("hwrite", 32'(hwrite_o), 32'(b.w));
                     check("haddr", haddr_o, b.a);
                     if (b.w) check("hwdata", hwdata_o, b.d);
                  end
               end
            end
            prev_valid = 1'b1;
         end
         prev_nonseq = (htrans_o == HTRANS_NONSEQ);
         prev_ready  = hready_i;
         prev_done   = done_o;
         prev_write  = hwrite_o;
         prev_addr   = haddr_o;
         prev_wdata  = hwdata_o;
      end
   end

   task automatic exp_tr(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus_t b;
      b.w = w; b.a = a; b.d = d;
      exp_bus.push_back(b);
   endtask

   task automatic exp_rsp(input logic [31:0] rd, input logic e);
      resp_t r;
      r.rdata = rd; r.err = e;
      exp_resp.push_back(r);
   endtask

   task automatic set_slave(input int w, input logic resp, input logic [31:0] rd);
      cfg_wait  = w;
      cfg_resp  = resp;
      cfg_rdata = rd;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      n = 0;
      while (busy_o && n < 300) begin
         @(posedge hclk_i); #1;
         n++;
      end
      if (busy_o) fail_now("idle_wait", "busy_o never dropped");
      req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
      @(posedge hclk_i); #1;
      req_i = 1'b0;
   endtask

   // Cycles counted from the edge that accepted the request to done_o being visible.
   task automatic run_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_cycles);
      int n;
      issue(we, size, uns, addr, wdata);
      n = 0;
      while (!done_o && n < 300) begin
         @(posedge hclk_i); #1;
         n++;
      end
      if (!done_o) fail_now(name, "no done_o within 300 cycles");
      else check({name, "_latency"}, 32'(n), 32'(exp_cycles));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_htrans"}, 32'(htrans_o), 32'd0);
      check({name, "_flags"}, 32'({hwrite_o, done_o, err_o, busy_o}), 32'd0);
      check({name, "_haddr"}, haddr_o, 32'd0);
      check({name, "_hwdata"}, hwdata_o, 32'd0);
      check({name, "_rdata"}, rdata_o, 32'd0);
   endtask

   initial begin
      req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0; addr_i = '0; wdata_i = '0;
      hreset_i = 1'b1;
      repeat (2) @(posedge hclk_i);
      #1;
      check_reset_outputs("reset");
      hreset_i = 1'b0;
      @(posedge hclk_i); #1;

      set_slave(3, 1'b0, 32'h80FF_1234);
      exp_tr(1'b0, 32'h100, '0); exp_rsp(32'hFFFF_FF80, 1'b0);
      run_req("ld_byte_signed", 1'b0, SZ_BYTE, 1'b0, 32'h103, '0, 4);

      set_slave(0, 1'b0, 32'h80FF_1234);
      exp_tr(1'b0, 32'h100, '0); exp_rsp(32'h0000_80FF, 1'b0);
      run_req("ld_half_unsigned", 1'b0, SZ_HALF, 1'b1, 32'h102, '0, 1);

      set_slave(2, 1'b0, 32'h0000_8001);
      exp_tr(1'b0, 32'h100, '0); exp_rsp(32'hFFFF_8001, 1'b0);
      run_req("ld_half_signed", 1'b0, SZ_HALF, 1'b0, 32'h100, '0, 3);

      set_slave(0, 1'b0, 32'h1234_56F0);
      exp_tr(1'b0, 32'h100, '0); exp_rsp(32'h0000_00F0, 1'b0);
      run_req("ld_byte_unsigned", 1'b0, SZ_BYTE, 1'b1, 32'h100, '0, 1);

      set_slave(1, 1'b0, 32'hDEAD_BEEF);
      exp_tr(1'b0, 32'h200, '0); exp_rsp(32'hDEAD_BEEF, 1'b0);
      run_req("ld_word", 1'b0, SZ_WORD, 1'b0, 32'h200, '0, 2);

      set_slave(0, 1'b0, 32'h1122_3344);
      exp_tr(1'b0, 32'h100, '0); exp_tr(1'b1, 32'h100, 32'h1122_AB44); exp_rsp('0, 1'b0);
      run_req("st_byte_rmw", 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h1234_56AB, 3);

      set_slave(1, 1'b0, 32'h1122_3344);
      exp_tr(1'b0, 32'h104, '0); exp_tr(1'b1, 32'h104, 32'h5A5A_3344); exp_rsp('0, 1'b0);
      run_req("st_half_rmw", 1'b1, SZ_HALF, 1'b0, 32'h106, 32'h0000_5A5A, 5);

      set_slave(0, 1'b0, '0);
      exp_tr(1'b1, 32'h300, 32'hCAFE_F00D); exp_rsp('0, 1'b0);
      run_req("st_word", 1'b1, SZ_WORD, 1'b0, 32'h300, 32'hCAFE_F00D, 1);

      exp_rsp('0, 1'b1);
      run_req("st_word_misaligned", 1'b1, SZ_WORD, 1'b0, 32'h102, 32'h1, 0);
      exp_rsp('0, 1'b1);
      run_req("ld_half_misaligned", 1'b0, SZ_HALF, 1'b0, 32'h103, '0, 0);
      exp_rsp('0, 1'b1);
      run_req("ld_size_illegal", 1'b0, 2'b11, 1'b0, 32'h100, '0, 0);

      set_slave(1, 1'b1, 32'h5555_5555);
      exp_tr(1'b0, 32'h400, '0); exp_rsp('0, 1'b1);
      run_req("ld_hresp", 1'b0, SZ_WORD, 1'b0, 32'h400, '0, 2);

      set_slave(0, 1'b1, 32'h5555_5555);
      exp_tr(1'b0, 32'h400, '0); exp_rsp('0, 1'b1);
      run_req("rmw_hresp", 1'b1, SZ_BYTE, 1'b0, 32'h402, 32'hEE, 1);

      set_slave(100000, 1'b0, '0);
      exp_rsp('0, 1'b1);
      run_req("timeout", 1'b0, SZ_WORD, 1'b0, 32'h500, '0, TMO);
      @(posedge hclk_i); #1;
      check("timeout_busy_after", 32'(busy_o), 32'd0);

      issue(1'b0, SZ_WORD, 1'b0, 32'h600, '0);
      repeat (3) @(posedge hclk_i);
      #1;
      check("mid_rd_busy", 32'(busy_o), 32'd1);
      hreset_i = 1'b1;
      #1;
      check_reset_outputs("mid_rd_reset");
      @(posedge hclk_i); #1;
      hreset_i = 1'b0;
      repeat (4) @(posedge hclk_i);
      #1;
      check("post_reset_busy", 32'(busy_o), 32'd0);
      check("post_reset_htrans", 32'(htrans_o), 32'(HTRANS_IDLE));

      set_slave(0, 1'b0, 32'h0123_4567);
      exp_tr(1'b0, 32'h600, '0); exp_rsp(32'h0123_4567, 1'b0);
      run_req("ld_after_reset", 1'b0, SZ_WORD, 1'b0, 32'h600, '0, 1);

      repeat (3) @(posedge hclk_i);
      #1;
      check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
      check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
